cam_frame_gen: RTL
==================

// Module: cam_frame_gen
// PURPOSE
//  Camera-side transmitter for the ECBot pixel bus. Emits cvclk/cvsync/chsync/ycbcr
//  frames, timed exactly as the image capture logic expects, as a synthesizable sensor stand-in.
//  Sits beside the ECBot top level for bring-up and self-test of the capture/SRAM path.
//  One frame is sent per start request; pixel data is a deterministic ramp.
// PARAMETERS
//  CLK_DIV    2    clk cycles per cvclk half-period (>=1)
//  ACT_PIX    255  cvclk periods per line with chsync high
//  BLANK_PIX  116  cvclk periods per line with chsync low (horizontal blanking)
//  ROWS       96   lines per frame
//  VS_PRE     3    cvclk periods from start accept to cvsync rise
//  CNT_W      9    width of pixel/line counters (must hold max(ACT_PIX,BLANK_PIX,ROWS))
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  start        in   1  frame request; sampled every clk
//  busy         out  1  high from start accept until frame_done
//  frame_done   out  1  one-clk pulse at end of frame
//  cvclk        out  1  pixel clock, free-running, 50% duty
//  cvsync       out  1  vertical sync, high for whole frame
//  chsync       out  1  horizontal sync, high during active pixels
//  ycbcr        out  8  pixel data
// BEHAVIOUR
//  - Reset: cvclk=0, cvsync=0, chsync=0, ycbcr=0, busy=0, frame_done=0, FSM=IDLE, counters=0.
//  - cvclk: divider counts 0..CLK_DIV-1, toggles on wrap; first rise CLK_DIV clks after reset.
//  - "fall tick" = clk cycle in which cvclk is driven 1->0. All of cvsync/chsync/ycbcr
//    update only on fall ticks, so they are stable around every cvclk rise.
//  - start accepted in IDLE on any clk (level; held high => back-to-back frames);
//    busy rises the next clk. start while busy is ignored.
//  - FSM (advances on fall ticks only):
//    IDLE -> PRE on accepted start (counter cleared).
//    PRE: VS_PRE fall ticks, all outputs 0; then cvsync=1, chsync=1 -> ACT.
//    ACT: ACT_PIX fall ticks; chsync=1, ycbcr=col (col 0..ACT_PIX-1, low 8 bits) -> BLANK.
//    BLANK: BLANK_PIX fall ticks; chsync=0, ycbcr=0; row++; row<ROWS -> ACT
//      else -> POST.
//    POST: one fall tick; cvsync=0, chsync=0; frame_done=1 for that clk, busy=0 next clk -> IDLE.
//  - Frame length: VS_PRE + ROWS*(ACT_PIX+BLANK_PIX) + 1 cvclk periods
//    (defaults: 3+96*371+1 = 35620).
//  - Counters compare with ==(N-1) then clear; no wrap beyond terminal count.
//  - ycbcr ramp truncates to 8 bits if ACT_PIX>256.
//  - reset mid-frame: all outputs to reset values on the next clk, frame abandoned, no frame_done.
//  - start coincident with POST fall tick: ignored (FSM not yet IDLE).
// CONFIGURATION
//  CAMGEN_ROW_RAMP_EN
//    defined: ycbcr = (col + row) mod 256 in ACT (diagonal pattern; row-slip visible).
//    undefined: ycbcr = col mod 256 (identical on every line).
//  Blanking data stays 0 in both cases.
// TESTING
//  1 reset held 5 clks, released -> all outputs 0; cvclk rises at clk 2, period 4 clks.
//  2 start pulse 1 clk -> busy next clk; cvsync rises on 3rd fall tick; 96 chsync high
//    pulses of 255 cvclk each, 116 low; frame_done after 35620 cvclk periods.
//  3 capture check on each cvclk rise with chsync=1 -> ycbcr = 0,1,..,254 per line;
//    with CAMGEN_ROW_RAMP_EN, line 5 starts at 5 and pixel 254 of line 5 = 3.
//  4 start re-asserted while busy (mid line 40) -> ignored, one frame_done only;
//    start held high -> second frame begins VS_PRE periods after first frame_done.
//  5 reset asserted during row 50 ACT -> next clk cvsync=chsync=ycbcr=0, busy=0,
//    no frame_done; new start afterwards yields full 96-line frame.
//  6 params CLK_DIV=1, ACT_PIX=4, BLANK_PIX=2, ROWS=2, VS_PRE=1 -> cvclk period 2 clks;
//    frame = 1+2*6+1 = 14 cvclk periods; data 0,1,2,3 per line.

Source files
------------

// File: rtl/cam_frame_gen.sv
// Synthesizable camera-side transmitter for the ECBot pixel bus: one cvsync/chsync/ycbcr frame per start.
// Optional feature macro CAMGEN_ROW_RAMP_EN: when defined, the row index is added to the ramp.
module cam_frame_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned ACT_PIX   = 255,
   parameter int unsigned BLANK_PIX = 116,
   parameter int unsigned ROWS      = 96,
   parameter int unsigned VS_PRE    = 3,
   parameter int unsigned CNT_W     = 9
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       frame_done_o,
   output logic       cvclk_o,
   output logic       cvsync_o,
   output logic       chsync_o,
   output logic [7:0] ycbcr_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ACT   = 3'd2,
      S_BLANK = 3'd3,
      S_POST  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               cvclk_q, cvclk_d;
   logic [CNT_W-1:0]   pix_q, pix_d;
   logic [CNT_W-1:0]   row_q, row_d;
   logic               cvsync_q, cvsync_d;
   logic               chsync_q, chsync_d;
   logic [7:0]         ycbcr_q, ycbcr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               div_wrap;
   logic               fall_tick;
   logic [7:0]         row_off;
   logic [7:0]         row_off_nxt;

   assign div_wrap  = (div_q == DIV_W'(CLK_DIV - 1));
   assign fall_tick = div_wrap && cvclk_q;

   // Per-line pixel offset: current row inside ACT, next row when re-entering ACT from BLANK.
`ifdef CAMGEN_ROW_RAMP_EN
   assign row_off     = 8'(row_q);
   assign row_off_nxt = 8'(row_q + CNT_W'(1));
`else
   assign row_off     = 8'd0;
   assign row_off_nxt = 8'd0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         cvclk_q  <= 1'b0;
         pix_q    <= '0;
         row_q    <= '0;
         cvsync_q <= 1'b0;
         chsync_q <= 1'b0;
         ycbcr_q  <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         cvclk_q  <= cvclk_d;
         pix_q    <= pix_d;
         row_q    <= row_d;
         cvsync_q <= cvsync_d;
         chsync_q <= chsync_d;
         ycbcr_q  <= ycbcr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
      cvclk_d  = div_wrap ? ~cvclk_q : cvclk_q;
      pix_d    = pix_q;
      row_d    = row_q;
      cvsync_d = cvsync_q;
      chsync_d = chsync_q;
      ycbcr_d  = ycbcr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_PRE;
               pix_d   = '0;
               row_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_PRE: begin
            if (fall_tick) begin
               if (pix_q == CNT_W'(VS_PRE - 1)) begin
                  state_d  = S_ACT;
                  pix_d    = '0;
                  cvsync_d = 1'b1;
                  chsync_d = 1'b1;
                  ycbcr_d  = row_off;
               end else begin
                  pix_d = pix_q + CNT_W'(1);
               end
            end
         end
         S_ACT: begin
            if (fall_tick) begin
               if (pix_q == CNT_W'(ACT_PIX - 1)) begin
                  state_d  = S_BLANK;
                  pix_d    = '0;
                  chsync_d = 1'b0;
                  ycbcr_d  = 8'd0;
               end else begin
                  pix_d   = pix_q + CNT_W'(1);
                  ycbcr_d = 8'(pix_q + CNT_W'(1)) + row_off;
               end
            end
         end
         S_BLANK: begin
            if (fall_tick && (pix_q == CNT_W'(BLANK_PIX - 1))) begin
               pix_d = '0;
               if (row_q == CNT_W'(ROWS - 1)) begin
                  state_d = S_POST;
               end else begin
                  state_d  = S_ACT;
                  row_d    = row_q + CNT_W'(1);
                  chsync_d = 1'b1;
                  ycbcr_d  = row_off_nxt;
               end
            end else if (fall_tick) begin
               pix_d = pix_q + CNT_W'(1);
            end
         end
         S_POST: begin
            if (fall_tick) begin
               state_d  = S_IDLE;
               cvsync_d = 1'b0;
               chsync_d = 1'b0;
               ycbcr_d  = 8'd0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o       = busy_q;
   assign frame_done_o = done_q;
   assign cvclk_o      = cvclk_q;
   assign cvsync_o     = cvsync_q;
   assign chsync_o     = chsync_q;
   assign ycbcr_o      = ycbcr_q;

endmodule
